// File: rtl/fsrc_seq_pkg.sv
// Shared types for the TX FSRC sequencer scheduler: FSM state encoding,
// completion status record and the requester-index width helper.
package fsrc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        HOLDOFF   = 3'd4
    } seq_state_e;

    // Sized for the largest supported requester count (8).
    localparam int MAX_ID_WIDTH = 3;

    typedef struct packed {
        logic [MAX_ID_WIDTH-1:0] id;
        logic                    timeout;
    } done_status_t;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fsrc_rr_arbiter.sv
// Round-robin winner select over a request vector, with a pointer that
// advances past the winner whenever a grant is taken.
module fsrc_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                take_i,
    output logic [ID_WIDTH-1:0] winner_o,
    output logic                valid_o
);

    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;

    // Scan from the highest offset down so the nearest request at/after ptr wins.
    always_comb begin
        int idx;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req_i[idx]) begin
                winner_o = ID_WIDTH'(idx);
                valid_o  = 1'b1;
            end else begin
                valid_o  = valid_o;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (take_i) begin
            if (winner_o == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner_o + ID_WIDTH'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fsrc_seq_scheduler.sv
// Shares one TX FSRC sequencer among NUM_REQ requesters: arbitrate, load the
// descriptor, pulse start, wait for tx_data_start or watchdog, then hold off.
module fsrc_seq_scheduler
    import fsrc_seq_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CTRL_WIDTH     = 40,
    parameter int COUNTER_WIDTH  = 4,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int HOLDOFF_CYCLES = 4,
    localparam int ID_WIDTH      = id_width(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [TIMEOUT_WIDTH-1:0]               timeout_cycles,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0][CTRL_WIDTH-1:0]     req_ctrl,
    input  logic [NUM_REQ-1:0][COUNTER_WIDTH-1:0]  req_accum_cnt,
    output logic [NUM_REQ-1:0]                     grant_ack,
    output logic                                   done_valid,
    output logic [ID_WIDTH-1:0]                    done_id,
    output logic                                   done_timeout,
    output logic                                   busy,
    output logic [CTRL_WIDTH-1:0]                  seq_next_ctrl_value,
    output logic [COUNTER_WIDTH-1:0]               seq_accum_reset_cnt,
    output logic                                   seq_start,
    input  logic                                   seq_tx_data_start
);

    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [HOLD_W-1:0]        HOLD_END = HOLD_W'(HOLDOFF_CYCLES - 1);

    seq_state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]      cur_id_q, cur_id_d;
    logic [CTRL_WIDTH-1:0]    seq_ctrl_q, seq_ctrl_d;
    logic [COUNTER_WIDTH-1:0] seq_cnt_q, seq_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;

    logic [NUM_REQ-1:0]       arb_req_s;
    logic [ID_WIDTH-1:0]      winner_s;
    logic                     winner_valid_s;
    logic                     take_s;
    logic                     wdog_hit_s;
    logic                     done_valid_s;
    done_status_t             done_s;

    assign arb_req_s = (state_q == IDLE && enable) ? req : '0;
    assign take_s    = (state_q == IDLE) && enable && winner_valid_s;

    fsrc_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (arb_req_s),
        .take_i   (take_s),
        .winner_o (winner_s),
        .valid_o  (winner_valid_s)
    );

    assign wdog_hit_s = (timeout_cycles != '0) && (wdog_q == (timeout_cycles - TO_ONE));

    // Next-state, descriptor capture, watchdog/holdoff counters and completion status.
    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        seq_ctrl_d   = seq_ctrl_q;
        seq_cnt_d    = seq_cnt_q;
        wdog_d       = wdog_q;
        hold_d       = hold_q;
        done_valid_s = 1'b0;
        done_s.id      = MAX_ID_WIDTH'(cur_id_q);
        done_s.timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_s) begin
                    state_d    = GRANT;
                    cur_id_d   = winner_s;
                    seq_ctrl_d = req_ctrl[winner_s];
                    seq_cnt_d  = req_accum_cnt[winner_s];
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                state_d = START;
                wdog_d  = '0;
            end
            START: begin
                state_d = WAIT_DONE;
                wdog_d  = '0;
            end
            WAIT_DONE: begin
                // A real completion outranks a watchdog expiry in the same cycle.
                if (seq_tx_data_start) begin
                    done_valid_s = 1'b1;
                    state_d      = HOLDOFF;
                    hold_d       = '0;
                end else if (wdog_hit_s) begin
                    done_valid_s   = 1'b1;
                    done_s.timeout = 1'b1;
                    state_d        = HOLDOFF;
                    hold_d         = '0;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + TO_ONE;
                end else begin
                    wdog_d = wdog_q;
                end
            end
            HOLDOFF: begin
                if (hold_q == HOLD_END) begin
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_id_q   <= '0;
            seq_ctrl_q <= '0;
            seq_cnt_q  <= '0;
            wdog_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            seq_ctrl_q <= seq_ctrl_d;
            seq_cnt_q  <= seq_cnt_d;
            wdog_q     <= wdog_d;
            hold_q     <= hold_d;
        end
    end

    // One-hot acknowledge for the captured winner while in GRANT.
    always_comb begin
        grant_ack = '0;
        if (state_q == GRANT) begin
            grant_ack[cur_id_q] = 1'b1;
        end else begin
            grant_ack = '0;
        end
    end

    assign seq_start           = (state_q == START);
    assign busy                = (state_q != IDLE);
    assign seq_next_ctrl_value = seq_ctrl_q;
    assign seq_accum_reset_cnt = seq_cnt_q;
    assign done_valid          = done_valid_s;
    assign done_timeout        = done_s.timeout;
    assign done_id             = done_s.id[ID_WIDTH-1:0];

endmodule

// File: tb/tb_fsrc_seq_scheduler.sv
// Directed bench for fsrc_seq_scheduler with a hand-timed sequencer response.
module tb_fsrc_seq_scheduler;

    localparam int NR = 4;
    localparam int CW = 40;
    localparam int KW = 4;
    localparam int TW = 16;
    localparam int HO = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [TW-1:0]      timeout_cycles;
    logic [NR-1:0]      req;
    logic [NR-1:0][CW-1:0] req_ctrl;
    logic [NR-1:0][KW-1:0] req_accum_cnt;
    logic [NR-1:0]      grant_ack;
    logic               done_valid;
    logic [1:0]         done_id;
    logic               done_timeout;
    logic               busy;
    logic [CW-1:0]      seq_next_ctrl_value;
    logic [KW-1:0]      seq_accum_reset_cnt;
    logic               seq_start;
    logic               seq_tx_data_start;

    integer errors = 0;
    integer checks = 0;
    integer cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsrc_seq_scheduler #(
        .NUM_REQ(NR), .CTRL_WIDTH(CW), .COUNTER_WIDTH(KW),
        .TIMEOUT_WIDTH(TW), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .timeout_cycles(timeout_cycles),
        .req(req), .req_ctrl(req_ctrl), .req_accum_cnt(req_accum_cnt),
        .grant_ack(grant_ack), .done_valid(done_valid), .done_id(done_id),
        .done_timeout(done_timeout), .busy(busy),
        .seq_next_ctrl_value(seq_next_ctrl_value), .seq_accum_reset_cnt(seq_accum_reset_cnt),
        .seq_start(seq_start), .seq_tx_data_start(seq_tx_data_start)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant();
        for (int c = 0; c < 40; c++) begin
            if (grant_ack != 4'b0000) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req = '0; seq_tx_data_start = 1'b0;
        timeout_cycles = '0; req_ctrl = '0; req_accum_cnt = '0;
        tick(3);
        checks++; if ({grant_ack, busy, seq_start, done_valid, done_timeout, done_id, seq_accum_reset_cnt} !== 14'b0)
            begin errors++; $display("FAIL reset_outputs: got %b want 0", {grant_ack, busy, seq_start, done_valid, done_timeout, done_id, seq_accum_reset_cnt}); end
        checks++; if (seq_next_ctrl_value !== 40'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", seq_next_ctrl_value); end
        reset = 1'b0; enable = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_id;
        int last_cyc;
        last_cyc = 0;
        for (int i = 0; i < NR; i++) begin
            req_ctrl[i] = 40'h1111111111 * 40'(i + 1);
            req_accum_cnt[i] = 4'(i + 1);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            wait_grant();
            checks++; if (grant_ack !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant_ack, 4'b0001 << exp_id); end
            checks++; if (seq_next_ctrl_value !== 40'h1111111111 * 40'(exp_id + 1)) begin errors++; $display("FAIL rr_ctrl[%0d]: got %h", k, seq_next_ctrl_value); end
            if (k > 0) begin
                checks++; if (cyc - last_cyc !== 4 + HO) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc - last_cyc, 4 + HO); end
            end
            last_cyc = cyc;
            if (k == 4) req = 4'b0000;
            tick(2);
            seq_tx_data_start = 1'b1; #1;
            checks++; if (done_valid !== 1'b1 || done_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_done[%0d]: got valid=%b id=%0d want 1/%0d", k, done_valid, done_id, exp_id); end
            tick(1); seq_tx_data_start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic test_single();
        req_ctrl[2] = 40'hA5A5A5A5A5; req_accum_cnt[2] = 4'd3; req = 4'b0100;
        wait_grant();
        checks++; if (grant_ack !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant_ack); end
        req = 4'b0000;
        tick(1);
        checks++; if (seq_start !== 1'b1 || seq_next_ctrl_value !== 40'hA5A5A5A5A5 || seq_accum_reset_cnt !== 4'd3)
            begin errors++; $display("FAIL single_start: got start=%b ctrl=%h cnt=%0d", seq_start, seq_next_ctrl_value, seq_accum_reset_cnt); end
        tick(5);
        checks++; if (done_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_waiting: got valid=%b busy=%b want 0/1", done_valid, busy); end
        tick(5);
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1 || done_id !== 2'd2 || done_timeout !== 1'b0)
            begin errors++; $display("FAIL single_done: got valid=%b id=%0d to=%b want 1/2/0", done_valid, done_id, done_timeout); end
        tick(1); seq_tx_data_start = 1'b0; #1;
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done_valid); end
        tick(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_holdoff_busy: got %b want 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0 || seq_next_ctrl_value !== 40'hA5A5A5A5A5)
            begin errors++; $display("FAIL single_idle: got busy=%b ctrl=%h", busy, seq_next_ctrl_value); end
    endtask

    task automatic test_timeout();
        timeout_cycles = 16'd20; req_ctrl[0] = 40'h00DEADBEEF; req = 4'b0001;
        wait_grant();
        checks++; if (grant_ack !== 4'b0001) begin errors++; $display("FAIL to_grant: got %b want 0001", grant_ack); end
        req = 4'b0000;
        tick(2);
        tick(18);
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", done_valid); end
        tick(1);
        checks++; if (done_valid !== 1'b1 || done_timeout !== 1'b1 || done_id !== 2'd0)
            begin errors++; $display("FAIL to_expire: got valid=%b to=%b id=%0d want 1/1/0", done_valid, done_timeout, done_id); end
        req_ctrl[1] = 40'h0123456789; req = 4'b0010;
        tick(5);
        checks++; if (grant_ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL to_holdoff_end: got grant=%b busy=%b", grant_ack, busy); end
        tick(1);
        checks++; if (grant_ack !== 4'b0010) begin errors++; $display("FAIL to_next_grant: got %b want 0010", grant_ack); end
        req = 4'b0000;
        tick(2);
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1 || done_timeout !== 1'b0 || done_id !== 2'd1)
            begin errors++; $display("FAIL to_next_done: got valid=%b to=%b id=%0d", done_valid, done_timeout, done_id); end
        tick(1); seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    task automatic test_timeout_zero();
        bit seen;
        seen = 1'b0;
        timeout_cycles = 16'd0; req = 4'b0100;
        wait_grant();
        checks++; if (grant_ack !== 4'b0100) begin errors++; $display("FAIL tz_grant: got %b want 0100", grant_ack); end
        req = 4'b0000;
        repeat (100) begin
            tick(1);
            if (done_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tz_stuck: got seen=%b busy=%b want 0/1", seen, busy); end
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1 || done_timeout !== 1'b0) begin errors++; $display("FAIL tz_release: got valid=%b to=%b", done_valid, done_timeout); end
        tick(1); seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    task automatic test_simultaneous();
        timeout_cycles = 16'd5; req = 4'b1000;
        wait_grant();
        checks++; if (grant_ack !== 4'b1000) begin errors++; $display("FAIL sim_grant: got %b want 1000", grant_ack); end
        req = 4'b0000;
        tick(5);
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL sim_early: got %b want 0", done_valid); end
        tick(1);
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1 || done_timeout !== 1'b0 || done_id !== 2'd3)
            begin errors++; $display("FAIL sim_both: got valid=%b to=%b id=%0d want 1/0/3", done_valid, done_timeout, done_id); end
        tick(1); seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    task automatic test_withdraw();
        bit seen;
        seen = 1'b0;
        timeout_cycles = 16'd0; req = 4'b0010;
        wait_grant();
        checks++; if (grant_ack !== 4'b0010) begin errors++; $display("FAIL wd_grant: got %b want 0010", grant_ack); end
        req = 4'b0000;
        tick(2);
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL wd_done: got %b want 1", done_valid); end
        tick(1); seq_tx_data_start = 1'b0; req = 4'b0001;
        tick(3); req = 4'b0000;
        repeat (10) begin
            tick(1);
            if (grant_ack != 4'b0000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wd_no_grant: got seen=%b busy=%b want 0/0", seen, busy); end
    endtask

    task automatic test_enable();
        bit seen;
        seen = 1'b0;
        req_ctrl[2] = 40'hCAFEF00D12; req = 4'b0100;
        wait_grant();
        checks++; if (grant_ack !== 4'b0100) begin errors++; $display("FAIL en_grant: got %b want 0100", grant_ack); end
        tick(2); enable = 1'b0;
        tick(2);
        seq_tx_data_start = 1'b1; #1;
        checks++; if (done_valid !== 1'b1 || done_id !== 2'd2) begin errors++; $display("FAIL en_complete: got valid=%b id=%0d", done_valid, done_id); end
        tick(1); seq_tx_data_start = 1'b0;
        repeat (15) begin
            tick(1);
            if (grant_ack != 4'b0000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_blocked: got seen=%b busy=%b want 0/0", seen, busy); end
        enable = 1'b1;
        tick(1);
        checks++; if (grant_ack !== 4'b0100) begin errors++; $display("FAIL en_resume: got %b want 0100", grant_ack); end
        req = 4'b0000;
        tick(2);
        seq_tx_data_start = 1'b1;
        tick(1); seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    task automatic test_accum_zero();
        req_ctrl[3] = 40'h00000000FF; req_accum_cnt[3] = 4'd0;
        seq_tx_data_start = 1'b1; req = 4'b1000;
        wait_grant();
        checks++; if (grant_ack !== 4'b1000 || done_valid !== 1'b0) begin errors++; $display("FAIL az_grant: got grant=%b valid=%b", grant_ack, done_valid); end
        req = 4'b0000;
        tick(1);
        checks++; if (seq_start !== 1'b1 || done_valid !== 1'b0 || seq_accum_reset_cnt !== 4'd0)
            begin errors++; $display("FAIL az_start: got start=%b valid=%b cnt=%0d", seq_start, done_valid, seq_accum_reset_cnt); end
        tick(1);
        checks++; if (done_valid !== 1'b1 || done_timeout !== 1'b0 || done_id !== 2'd3)
            begin errors++; $display("FAIL az_done: got valid=%b to=%b id=%0d want 1/0/3", done_valid, done_timeout, done_id); end
        tick(1);
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL az_holdoff_ignore: got %b want 0", done_valid); end
        seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    task automatic test_async_reset();
        timeout_cycles = 16'd0; req = 4'b0100;
        wait_grant();
        req = 4'b0000;
        tick(3);
        #2; reset = 1'b1; seq_tx_data_start = 1'b1; #1;
        checks++; if ({grant_ack, busy, seq_start, done_valid, done_timeout, done_id, seq_accum_reset_cnt} !== 14'b0 || seq_next_ctrl_value !== 40'h0)
            begin errors++; $display("FAIL ar_immediate: got %b ctrl=%h want 0", {grant_ack, busy, seq_start, done_valid, done_timeout, done_id, seq_accum_reset_cnt}, seq_next_ctrl_value); end
        tick(2);
        checks++; if (done_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_held: got valid=%b busy=%b want 0/0", done_valid, busy); end
        reset = 1'b0; seq_tx_data_start = 1'b0; req = 4'b1010;
        wait_grant();
        checks++; if (grant_ack !== 4'b0010) begin errors++; $display("FAIL ar_ptr_zero: got %b want 0010", grant_ack); end
        req = 4'b0000;
        tick(2);
        seq_tx_data_start = 1'b1;
        tick(1); seq_tx_data_start = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_timeout_zero();
        test_simultaneous();
        test_withdraw();
        test_enable();
        test_accum_zero();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsrc_seq_scheduler.md
Name: fsrc_seq_scheduler

Overview:
- Shares one TX FSRC sequencer between NUM_REQ software/hardware requesters.
- Each request carries a sequence descriptor: ctrl value and accumulator-reset count.
- Round-robin arbiter grants one request. The block loads the sequencer configuration, pulses its start, waits for tx_data_start (or a timeout), then reports completion.
- Sits between the regmap/DMA requesters and the sequencer's reg_start/next_ctrl_value/accum_reset_cnt inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CTRL_WIDTH, 40, width of the ctrl descriptor field.
- COUNTER_WIDTH, 4, width of the accum-reset count field.
- TIMEOUT_WIDTH, 16, width of the watchdog counter.
- HOLDOFF_CYCLES, 4, idle cycles after completion before the next grant (min 1).

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  grant enable; low blocks new grants.
- timeout_cycles  in  TIMEOUT_WIDTH  WAIT_DONE watchdog limit; 0 disables the watchdog.
- req  in  NUM_REQ  level request per requester.
- req_ctrl  in  NUM_REQ x CTRL_WIDTH  per-requester ctrl descriptor.
- req_accum_cnt  in  NUM_REQ x COUNTER_WIDTH  per-requester accum-reset count.
- grant_ack  out  NUM_REQ  one-hot, 1-cycle pulse on acceptance.
- done_valid  out  1  1-cycle completion pulse.
- done_id  out  $clog2(NUM_REQ)  requester index of the completed sequence.
- done_timeout  out  1  qualifies done_valid: 1 = watchdog expired.
- busy  out  1  high from grant until HOLDOFF ends.
- seq_next_ctrl_value  out  CTRL_WIDTH  held configuration to the sequencer.
- seq_accum_reset_cnt  out  COUNTER_WIDTH  held configuration to the sequencer.
- seq_start  out  1  1-cycle start pulse to the sequencer.
- seq_tx_data_start  in  1  completion indication from the sequencer.

Behaviour:
- Reset (async assert, sync release): state IDLE, RR pointer 0. All outputs 0, including seq_* config and done_id.
- States: IDLE -> GRANT -> START -> WAIT_DONE -> HOLDOFF -> IDLE.
- IDLE:
  - Go to GRANT when enable=1 and |req.
  - Winner = first set req at or after the RR pointer, wrapping.
- GRANT (1 cycle):
  - grant_ack[winner]=1.
  - Capture req_ctrl/req_accum_cnt[winner] into seq_* registers and the winner index into cur_id.
  - RR pointer <= winner+1 mod NUM_REQ.
- START (1 cycle):
  - seq_start=1. The seq_* config has been stable for ≥1 cycle before seq_start.
- WAIT_DONE:
  - seq_tx_data_start is sampled only in this state; it is ignored in IDLE/GRANT/START/HOLDOFF.
  - On seq_tx_data_start=1: done_valid=1, done_timeout=0, done_id=cur_id, next HOLDOFF.
  - Watchdog counts cycles spent in WAIT_DONE, starting at 0 on entry.
  - If timeout_cycles≠0 and the count reaches timeout_cycles-1 without seq_tx_data_start: done_valid=1, done_timeout=1, next HOLDOFF.
  - If both occur in the same cycle, success wins (done_timeout=0).
- HOLDOFF:
  - Lasts exactly HOLDOFF_CYCLES cycles, then IDLE.
  - No grant is made; seq_* config holds.
- Config holding: seq_* outputs change only in GRANT. They stay stable through completion and idle.
- busy=1 in GRANT, START, WAIT_DONE and HOLDOFF.
- Request rules:
  - Requester holds req and its descriptor until grant_ack.
  - Deasserting req before grant withdraws it.
  - req still high after grant_ack is treated as a new request.
- enable=0 mid-sequence: current sequence runs to completion; only IDLE->GRANT is blocked.
- accum_cnt=0 descriptor: the sequencer holds tx_data_start high, so completion occurs on the first WAIT_DONE cycle (latency seq_start->done_valid = 1 cycle).
- Minimum grant-to-grant spacing = 4 + HOLDOFF_CYCLES cycles (GRANT + START + ≥1 WAIT_DONE + HOLDOFF + IDLE evaluation).
- Reset mid-operation: immediate return to IDLE. No done_valid is emitted for the aborted sequence.
- Watchdog width: counter saturates at all-ones; it never wraps.

Decomposition:
- Package fsrc_seq_pkg:
  - state enum (IDLE, GRANT, START, WAIT_DONE, HOLDOFF).
  - done-status struct {id, timeout}.
  - localparam ID_WIDTH = $clog2(NUM_REQ) helper function.
- Sub-module fsrc_rr_arbiter:
  - Combinational winner select from req + pointer, plus a registered pointer update on grant.
  - Parameterised by NUM_REQ and reused by future RX sequencer scheduling.

Test Plan:
- Single request: req[2]=1, ctrl=0xA5A5A5A5A5, cnt=3; sequencer model asserts tx_data_start 10 cycles after seq_start. Expect:
  - grant_ack=4'b0100.
  - seq_start 1 cycle later with seq_next_ctrl_value=0xA5A5A5A5A5, seq_accum_reset_cnt=3.
  - done_valid with done_id=2, done_timeout=0.
  - busy low after 4 holdoff cycles.
- Round-robin fairness: req=4'b1111 held continuously. Expect grant order 0,1,2,3,0 and one done_valid per grant with matching done_id.
- Timeout: timeout_cycles=20, sequencer never responds. Expect:
  - done_valid with done_timeout=1 exactly 20 cycles after WAIT_DONE entry.
  - Next request granted after holdoff.
  - With timeout_cycles=0 the block remains in WAIT_DONE indefinitely.
- Simultaneous events: tx_data_start on the same cycle the watchdog expires -> done_timeout=0. req withdrawn one cycle before IDLE evaluation -> no grant.
- enable/accum=0: enable dropped during WAIT_DONE -> sequence completes, no further grant until enable=1. Descriptor cnt=0 with tx_data_start stuck high -> done_valid 1 cycle after seq_start.
- Async reset asserted in WAIT_DONE -> all outputs 0 immediately (no clock edge), no done_valid. Post-release request served from RR pointer 0.
